// File: rtl/wb_write_queue.sv
// Register-file write-back queue: buffers writes in a circular FIFO, issues at most one
// write per cycle, and exposes two combinational youngest-first bypass lookups.
module wb_write_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_W-1:0]     in_reg,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  drain_en,
  output logic                  regWrite,
  output logic [ADDR_W-1:0]     writeReg,
  output logic [DATA_W-1:0]     writeData,
  output logic [$clog2(DEPTH):0] count,
  input  logic [ADDR_W-1:0]     look1_reg,
  input  logic [ADDR_W-1:0]     look2_reg,
  output logic                  look1_hit,
  output logic                  look2_hit,
  output logic [DATA_W-1:0]     look1_data,
  output logic [DATA_W-1:0]     look2_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              enq, deq;

  // Ready depends only on registered occupancy, so a full queue stays closed
  // even in a cycle that also dequeues.
  assign in_ready = (count_q < CNT_W'(DEPTH));

  // Writes to register 0 complete the handshake but are dropped.
  assign enq = in_valid && in_ready && (in_reg != '0);
  assign deq = drain_en && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rw_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (deq) begin
      rw_d    = 1'b1;
      wreg_d  = ent_reg_q[head_q];
      wdata_d = ent_data_q[head_q];
      head_d  = head_q + PTR_W'(1);
    end
    if (enq) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rw_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rw_q    <= rw_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_reg_q[tail_q]  <= in_reg;
      ent_data_q[tail_q] <= in_data;
    end
  end

  // Oldest source first so that younger matches overwrite: output stage, then head..tail.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] r);
    logic [DATA_W:0] res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (r != '0) begin
      if (rw_q && (wreg_q == r)) begin
        res = {1'b1, wdata_q};
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if ((CNT_W'(i) < count_q) && (ent_reg_q[idx] == r)) begin
          res = {1'b1, ent_data_q[idx]};
        end
      end
    end
    return res;
  endfunction

  assign {look1_hit, look1_data} = lookup(look1_reg);
  assign {look2_hit, look2_data} = lookup(look2_reg);

  assign regWrite  = rw_q;
  assign writeReg  = wreg_q;
  assign writeData = wdata_q;
  assign count     = count_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        drain_en;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [2:0]  count;
  logic [4:0]  look1_reg, look2_reg;
  logic        look1_hit, look2_hit;
  logic [31:0] look1_data, look2_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_rw;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  wb_write_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .drain_en(drain_en),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .count(count),
    .look1_reg(look1_reg), .look2_reg(look2_reg),
    .look1_hit(look1_hit), .look2_hit(look2_hit),
    .look1_data(look1_data), .look2_data(look2_data)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mq.delete();
    m_rw = 1'b0; m_reg = '0; m_data = '0;
  endfunction

  // Youngest pending write wins; the issuing write is the oldest source.
  function automatic void model_look(input logic [4:0] r, output logic h, output logic [31:0] d);
    h = 1'b0; d = '0;
    if (r == 0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].r == r) begin h = 1'b1; d = mq[i].d; return; end
    end
    if (m_rw && m_reg == r) begin h = 1'b1; d = m_data; end
  endfunction

  // Advance one clock and apply the same transaction to the model.
  task automatic cycle();
    bit acc, dq;
    ent_t e;
    acc = in_valid && (mq.size() < DEPTH);
    dq  = drain_en && (mq.size() > 0);
    e.r = in_reg; e.d = in_data;
    @(posedge clk); #1;
    if (dq) begin
      ent_t h;
      h = mq.pop_front();
      m_rw = 1'b1; m_reg = h.r; m_data = h.d;
    end else begin
      m_rw = 1'b0;
    end
    if (acc && e.r != 0) mq.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_reg = 5'd5; in_data = 32'h1234;
    drain_en = 1'b1; look1_reg = 5'd5; look2_reg = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (regWrite !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL reset_hold: regWrite=%b count=%0d required 0/0", regWrite, count);
    end
    in_valid = 1'b0; rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (regWrite !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || look1_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: regWrite=%b count=%0d in_ready=%b hit=%b required 0/0/1/0",
               regWrite, count, in_ready, look1_hit);
    end
  endtask

  task automatic test_single_write();
    drain_en = 1'b1; in_valid = 1'b1; in_reg = 5'd3; in_data = 32'h0000_00AA; look1_reg = 5'd3;
    cycle();
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (count !== 3'd1 || look1_hit !== 1'b1 || look1_data !== 32'hAA) begin
      n_fail++;
      $display("FAIL single_enq: count=%0d hit=%b data=%h required 1/1/aa", count, look1_hit, look1_data);
    end
    cycle();
    n_tests++;
    if (regWrite !== 1'b1 || writeReg !== 5'd3 || writeData !== 32'hAA || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_write: rw=%b reg=%0d data=%h count=%0d required 1/3/aa/0",
               regWrite, writeReg, writeData, count);
    end
    cycle();
    n_tests++;
    if (regWrite !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: regWrite=%b required 0", regWrite);
    end
  endtask

  task automatic test_fill_stall();
    drain_en = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_reg = 5'(i); in_data = 32'(10 * i);
      cycle();
    end
    in_reg = 5'd5; in_data = 32'd50;
    #1;
    n_tests++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: count=%0d in_ready=%b required 4/0", count, in_ready);
    end
    cycle();
    n_tests++;
    if (count !== 3'd4 || regWrite !== 1'b0) begin
      n_fail++; $display("FAIL fill_reject: count=%0d rw=%b required 4/0", count, regWrite);
    end
    drain_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (i == 2) in_valid = 1'b0;
      n_tests++;
      if (regWrite !== 1'b1 || writeReg !== 5'(i) || writeData !== 32'(10 * i)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: rw=%b reg=%0d data=%0d required 1/%0d/%0d",
                 i, regWrite, writeReg, writeData, i, 10 * i);
      end
      if (i == 1) begin
        n_tests++;
        if (in_ready !== 1'b1 || count !== 3'd3) begin
          n_fail++; $display("FAIL drain_ready: in_ready=%b count=%0d required 1/3", in_ready, count);
        end
      end
    end
    cycle();
    n_tests++;
    if (regWrite !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL drain_done: rw=%b count=%0d required 0/0", regWrite, count);
    end
  endtask

  task automatic test_youngest();
    drain_en = 1'b0; in_valid = 1'b1; in_reg = 5'd2; look1_reg = 5'd2;
    in_data = 32'd7; cycle();
    in_data = 32'd9; cycle();
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (look1_hit !== 1'b1 || look1_data !== 32'd9) begin
      n_fail++; $display("FAIL young_queued: hit=%b data=%0d required 1/9", look1_hit, look1_data);
    end
    drain_en = 1'b1;
    cycle();
    n_tests++;
    if (regWrite !== 1'b1 || writeData !== 32'd7 || look1_data !== 32'd9) begin
      n_fail++;
      $display("FAIL young_out7: rw=%b wdata=%0d look=%0d required 1/7/9", regWrite, writeData, look1_data);
    end
    cycle();
    n_tests++;
    if (regWrite !== 1'b1 || writeData !== 32'd9 || look1_hit !== 1'b1 || look1_data !== 32'd9) begin
      n_fail++;
      $display("FAIL young_out9: rw=%b wdata=%0d hit=%b look=%0d required 1/9/1/9",
               regWrite, writeData, look1_hit, look1_data);
    end
    cycle();
    n_tests++;
    if (regWrite !== 1'b0 || look1_hit !== 1'b0 || look1_data !== 32'd0) begin
      n_fail++;
      $display("FAIL young_gone: rw=%b hit=%b data=%h required 0/0/0", regWrite, look1_hit, look1_data);
    end
  endtask

  task automatic test_reg0();
    drain_en = 1'b1; in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hFFFF_FFFF; look1_reg = 5'd0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reg0_ready: in_ready=%b required 1", in_ready);
    end
    cycle();
    in_valid = 1'b0;
    cycle();
    n_tests++;
    if (count !== 3'd0 || regWrite !== 1'b0 || look1_hit !== 1'b0 || look1_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reg0_drop: count=%0d rw=%b hit=%b data=%h required 0/0/0/0",
               count, regWrite, look1_hit, look1_data);
    end
  endtask

  task automatic test_random();
    logic        eh1, eh2;
    logic [31:0] ed1, ed2;
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_reg    = 5'($urandom_range(0, 7));
      in_data   = $urandom;
      drain_en  = (n % 64 < 40) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
      look1_reg = 5'($urandom_range(0, 7));
      look2_reg = 5'($urandom_range(0, 7));
      #1;
      model_look(look1_reg, eh1, ed1);
      model_look(look2_reg, eh2, ed2);
      n_tests++;
      if (in_ready !== (mq.size() < DEPTH) || count !== 3'(mq.size())) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: in_ready=%b count=%0d required %b/%0d",
                 n, in_ready, count, (mq.size() < DEPTH), mq.size());
      end
      n_tests++;
      if (look1_hit !== eh1 || look1_data !== ed1 || look2_hit !== eh2 || look2_data !== ed2) begin
        n_fail++;
        $display("FAIL rand_look[%0d]: r1=%0d %b/%h r2=%0d %b/%h required %b/%h %b/%h",
                 n, look1_reg, look1_hit, look1_data, look2_reg, look2_hit, look2_data,
                 eh1, ed1, eh2, ed2);
      end
      cycle();
      n_tests++;
      if (regWrite !== m_rw || writeReg !== m_reg || writeData !== m_data) begin
        n_fail++;
        $display("FAIL rand_write[%0d]: rw=%b reg=%0d data=%h required %b/%0d/%h",
                 n, regWrite, writeReg, writeData, m_rw, m_reg, m_data);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    drain_en = 1'b1; in_valid = 1'b0;
    repeat (3) cycle();
    drain_en = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_reg = 5'(i + 10); in_data = 32'(i + 100);
      cycle();
    end
    in_valid = 1'b0; drain_en = 1'b1; look1_reg = 5'd12; look2_reg = 5'd11;
    cycle();
    n_tests++;
    if (count !== 3'd3 || regWrite !== 1'b1 || look1_hit !== 1'b1 || look2_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: count=%0d rw=%b h1=%b h2=%b required 3/1/1/1",
               count, regWrite, look1_hit, look2_hit);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (regWrite !== 1'b0 || count !== 3'd0 || look1_hit !== 1'b0 || look2_hit !== 1'b0 ||
        writeReg !== 5'd0 || writeData !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_async: rw=%b count=%0d h1=%b h2=%b reg=%0d data=%h required all 0",
               regWrite, count, look1_hit, look2_hit, writeReg, writeData);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (regWrite !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_after[%0d]: rw=%b count=%0d in_ready=%b required 0/0/1",
                 i, regWrite, count, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_stall();
    test_youngest();
    test_reg0();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Write-back queue that sits on the write side of the pipeline's 32x32 register file. It accepts register-write requests from the write-back stage through a valid/ready handshake, buffers up to DEPTH of them, and drives the register file's write port (regWrite, writeReg, writeData) at most once per cycle. Two combinational lookup ports let the decode stage read values that are still in flight, so operand reads stay coherent while writes are pending.

## Interface
- DEPTH, 4: number of queue entries. Must be a power of two, at least 2.
- ADDR_W, 5: register index width.
- DATA_W, 32: data width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept; equals (count < DEPTH) from registered state only.
- in_reg  in  ADDR_W  destination register.
- in_data  in  DATA_W  value to write.
- drain_en  in  1  when 0, the head entry is held and no new write is issued.
- regWrite  out  1  registered write strobe to the register file.
- writeReg  out  ADDR_W  registered write index.
- writeData  out  DATA_W  registered write data.
- count  out  $clog2(DEPTH)+1  number of queued entries (excludes the output stage).
- look1_reg, look2_reg  in  ADDR_W  lookup indices.
- look1_hit, look2_hit  out  1  a pending write to that register exists.
- look1_data, look2_data  out  DATA_W  value of the youngest pending write; 0 when there is no hit.

## Operation
- Storage is a circular FIFO with head and tail pointers of width $clog2(DEPTH). The pointers wrap modulo DEPTH; the count register distinguishes full from empty.
- Enqueue happens when in_valid && in_ready at a rising edge.
  - A request with in_reg == 0 is accepted (handshake completes) but is not stored. Register 0 is never written.
- Output stage, updated at every rising edge:
  - If drain_en && count > 0: load the head entry into writeReg/writeData, set regWrite=1, advance head.
  - Otherwise: regWrite=0. writeReg and writeData hold their previous values.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
  - When full, in_ready=0, even if a dequeue occurs in the same cycle. There is no combinational ready path.
- Lookup is combinational over the valid FIFO entries plus the output stage when regWrite=1.
  - Priority is youngest first: the entry nearest the tail, then older entries, then the output stage.
  - look*_reg == 0 always gives hit=0 and data=0.
- Write order to the register file is strictly enqueue order, so a later write to the same register always lands last.
- Reset (asynchronous assert, at any time including mid-drain):
  - head=tail=count=0, regWrite=0, writeReg=0, writeData=0.
  - in_ready=1 once rst is deasserted.
  - Pending entries are discarded. Lookups return hit=0.

## Timing
- Enqueue at edge N makes the entry visible to lookup from N onward (after the edge) and raises count at N.
- Earliest write: at edge N+1 the entry moves to the output stage. regWrite=1 for the cycle between edges N+1 and N+2. The register file commits it on that cycle's falling edge.
- Throughput: one write per cycle in and one write per cycle out. A continuous stream with drain_en=1 keeps count ≤ 1.
- drain_en=0 for k cycles while enqueuing every cycle: count reaches DEPTH after DEPTH cycles, then in_ready=0 until drain resumes.
  - After drain_en rises at edge M, the first dequeue happens at edge M and in_ready returns 1 after edge M.
- The output stage remains a bypass source for exactly one cycle after leaving the FIFO.

## Test plan
- **Reset:** hold rst=0 while driving in_valid=1, then release. Required: regWrite=0, count=0, in_ready=1, look1_hit=0 before the first edge.
- **Single write:** enqueue reg 3 = 32'h0000_00AA at edge 1. Required:
  - count=1 after edge 1 and look1_reg=3 gives hit with data AA.
  - After edge 2: regWrite=1, writeReg=3, writeData=AA, count=0.
  - After edge 3: regWrite=0.
- **Fill and stall:** with drain_en=0, enqueue regs 1,2,3,4 = 10,20,30,40. Required:
  - count=4 and in_ready=0; a 5th request (reg 5) is not accepted.
  - Raise drain_en: writes appear in order 1/10, 2/20, 3/30, 4/40 on consecutive cycles, then the 5th request is accepted.
- **Youngest-wins bypass:** with drain_en=0, enqueue reg 2 = 7 then reg 2 = 9. Required:
  - look1_reg=2 gives data 9.
  - After draining, the register file writes are 7 then 9.
  - On the cycle the output stage holds 7, lookup still returns 9.
- **Register 0:** enqueue reg 0 = FFFF_FFFF. Required: handshake completes, count stays 0, no regWrite, look1_reg=0 gives hit=0.
- **Mid-operation reset:** assert rst asynchronously between edges while count=3 and regWrite=1. Required: regWrite, count and all hits drop to 0 immediately, with no subsequent writes.
